// File: rtl/sdio_cmd_engine.sv
// SD/SDIO CMD-line engine: divided sd_clk, CRC7 command serialiser and
// short/long response capture with NCR timeout, CRC/end-bit checks, NCC gap.
// Ports: cmd_* request (valid/ready), resp_* result (valid/ready), sd_* pins.
// Optional SDIO_CMD_BUSY_EN adds sd_dat0/cmd_busy and a busy wait after R1b.
module sdio_cmd_engine #(
  parameter int CLK_DIV      = 4,
  parameter int TIMEOUT      = 64,
  parameter int GAP_CYCLES   = 8,
  parameter int BUSY_TIMEOUT = 1024
) (
  input  logic         axi_clk,
  input  logic         axi_resetn,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_arg,
  input  logic [1:0]   cmd_resp_type,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [5:0]   resp_index,
  output logic [127:0] resp_data,
  output logic [3:0]   resp_status,
  output logic         sd_clk_out,
  input  logic         sd_cmd_in,
  output logic         sd_cmd_out,
  output logic         sd_cmd_dir
`ifdef SDIO_CMD_BUSY_EN
  ,
  input  logic         sd_dat0,
  input  logic         cmd_busy
`endif
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int T1 = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
  localparam int TM = (T1 > BUSY_TIMEOUT) ? T1 : BUSY_TIMEOUT;
  localparam int TW = $clog2(TM + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX,
    S_WAIT,
    S_RX,
    S_GAP,
    S_DONE
`ifdef SDIO_CMD_BUSY_EN
    ,
    S_BUSY
`endif
  } state_t;

  state_t         state;
  logic [DW-1:0]  div_cnt;
  logic [47:0]    tx_sr;
  logic [126:0]   rx_sr;
  logic [7:0]     bit_cnt;
  logic [TW-1:0]  tmr;
  logic [1:0]     rtype;
`ifdef SDIO_CMD_BUSY_EN
  logic           busy_req;
`endif

  logic           div_hit;
  logic           rise;
  logic           fall;
  logic [127:0]   rx_next;
  logic           rx_last;
  logic [39:0]    hdr;

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  // Strobes fire in the cycle whose edge toggles sd_clk_out.
  assign div_hit = (div_cnt == DW'(CLK_DIV - 1));
  assign rise    = div_hit && !sd_clk_out;
  assign fall    = div_hit && sd_clk_out;
  assign rx_next = {rx_sr, sd_cmd_in};
  assign rx_last = (bit_cnt == ((rtype == 2'd3) ? 8'd135 : 8'd47));
  assign hdr     = {2'b01, cmd_index, cmd_arg};

  always_ff @(posedge axi_clk) begin
    if (!axi_resetn) begin
      div_cnt    <= '0;
      sd_clk_out <= 1'b0;
    end else if (div_hit) begin
      div_cnt    <= '0;
      sd_clk_out <= !sd_clk_out;
    end else begin
      div_cnt    <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge axi_clk) begin
    if (!axi_resetn) begin
      state       <= S_IDLE;
      cmd_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_index  <= '0;
      resp_data   <= '0;
      resp_status <= '0;
      sd_cmd_out  <= 1'b1;
      sd_cmd_dir  <= 1'b0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      bit_cnt     <= '0;
      tmr         <= '0;
      rtype       <= '0;
`ifdef SDIO_CMD_BUSY_EN
      busy_req    <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready   <= 1'b0;
            tx_sr       <= {hdr, crc7(hdr), 1'b1};
            rtype       <= cmd_resp_type;
            bit_cnt     <= '0;
            resp_index  <= '0;
            resp_data   <= '0;
            resp_status <= '0;
`ifdef SDIO_CMD_BUSY_EN
            busy_req    <= cmd_busy;
`endif
            state       <= S_TX;
          end
        end
        S_TX: begin
          if (fall) begin
            if (bit_cnt == 8'd48) begin
              sd_cmd_dir <= 1'b0;
              sd_cmd_out <= 1'b1;
              bit_cnt    <= '0;
              tmr        <= '0;
              state      <= (rtype == 2'd0) ? S_GAP : S_WAIT;
            end else begin
              sd_cmd_dir <= 1'b1;
              sd_cmd_out <= tx_sr[47];
              tx_sr      <= {tx_sr[46:0], 1'b0};
              bit_cnt    <= bit_cnt + 8'd1;
            end
          end
        end
        S_WAIT: begin
          if (rise) begin
            if (!sd_cmd_in) begin
              // The start bit is frame bit 0 of the count.
              rx_sr   <= '0;
              bit_cnt <= 8'd1;
              state   <= S_RX;
            end else if (tmr == TW'(TIMEOUT - 1)) begin
              resp_status[0] <= 1'b1;
              tmr            <= '0;
              state          <= S_GAP;
            end else begin
              tmr <= tmr + 1'b1;
            end
          end
        end
        S_RX: begin
          if (rise) begin
            rx_sr   <= rx_next[126:0];
            bit_cnt <= bit_cnt + 8'd1;
            if (rx_last) begin
              resp_status[2] <= !sd_cmd_in;
              if (rtype == 2'd3) begin
                resp_data <= rx_next;
              end else begin
                resp_index <= rx_next[45:40];
                resp_data  <= {96'd0, rx_next[39:8]};
                if (rtype == 2'd1 &&
                    crc7(rx_next[47:8]) != rx_next[7:1])
                  resp_status[1] <= 1'b1;
              end
              tmr   <= '0;
`ifdef SDIO_CMD_BUSY_EN
              state <= (rtype == 2'd1 && busy_req) ? S_BUSY : S_GAP;
`else
              state <= S_GAP;
`endif
            end
          end
        end
`ifdef SDIO_CMD_BUSY_EN
        S_BUSY: begin
          if (rise) begin
            if (sd_dat0) begin
              tmr   <= '0;
              state <= S_GAP;
            end else if (tmr == TW'(BUSY_TIMEOUT - 1)) begin
              resp_status[3] <= 1'b1;
              tmr            <= '0;
              state          <= S_GAP;
            end else begin
              tmr <= tmr + 1'b1;
            end
          end
        end
`endif
        S_GAP: begin
          if (rise) begin
            if (tmr == TW'(GAP_CYCLES - 1)) begin
              resp_valid <= 1'b1;
              state      <= S_DONE;
            end else begin
              tmr <= tmr + 1'b1;
            end
          end
        end
        S_DONE: begin
          if (resp_valid && resp_ready) begin
            resp_valid <= 1'b0;
            cmd_ready  <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdio_cmd_engine.sv
// Scoreboard bench for sdio_cmd_engine: directed commands, card model,
// queued expectations checked by TX-line and response monitors.
module tb_sdio_cmd_engine;

  localparam int LIM = 20000;

  typedef struct {
    logic [5:0]   idx;
    logic [127:0] data;
    logic [3:0]   st;
  } exp_t;

  logic         axi_clk = 1'b0;
  logic         axi_resetn = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [5:0]   cmd_index = '0;
  logic [31:0]  cmd_arg = '0;
  logic [1:0]   cmd_resp_type = '0;
  logic         resp_valid;
  logic         resp_ready = 1'b0;
  logic [5:0]   resp_index;
  logic [127:0] resp_data;
  logic [3:0]   resp_status;
  logic         sd_clk_out;
  logic         sd_cmd_in = 1'b1;
  logic         sd_cmd_out;
  logic         sd_cmd_dir;
`ifdef SDIO_CMD_BUSY_EN
  logic         sd_dat0 = 1'b1;
  logic         cmd_busy = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int valid_cyc = 0;

  exp_t        exp_q[$];
  logic [47:0] tx_q[$];

  sdio_cmd_engine dut (
    .axi_clk       (axi_clk),
    .axi_resetn    (axi_resetn),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_index     (cmd_index),
    .cmd_arg       (cmd_arg),
    .cmd_resp_type (cmd_resp_type),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_index    (resp_index),
    .resp_data     (resp_data),
    .resp_status   (resp_status),
    .sd_clk_out    (sd_clk_out),
    .sd_cmd_in     (sd_cmd_in),
    .sd_cmd_out    (sd_cmd_out),
    .sd_cmd_dir    (sd_cmd_dir)
`ifdef SDIO_CMD_BUSY_EN
    ,
    .sd_dat0       (sd_dat0),
    .cmd_busy      (cmd_busy)
`endif
  );

  always #5 axi_clk = !axi_clk;
  always @(posedge axi_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [135:0] act,
                     input logic [135:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push_resp(input logic [5:0] i, input logic [127:0] d,
                           input logic [3:0] s);
    exp_t e;
    e.idx = i;
    e.data = d;
    e.st = s;
    exp_q.push_back(e);
  endtask

  // Response monitor: pop and compare on every presented response.
  initial begin
    exp_t e;
    forever begin
      @(posedge axi_clk);
      #1;
      if (resp_valid && !resp_ready) begin
        valid_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", {132'd0, resp_status}, 136'h1_0000);
        end else begin
          e = exp_q.pop_front();
          chk("resp_index", resp_index, e.idx);
          chk("resp_data", resp_data, e.data);
          chk("resp_status", resp_status, e.st);
        end
        resp_ready = 1'b1;
        @(posedge axi_clk);
        #1;
        resp_ready = 1'b0;
      end
    end
  end

  // CMD-line monitor: capture driven bits on sd_clk rising edges.
  initial begin
    logic [47:0] cap;
    logic [47:0] want;
    int n;
    n = 0;
    cap = '0;
    forever begin
      @(posedge sd_clk_out);
      if (sd_cmd_dir) begin
        cap = {cap[46:0], sd_cmd_out};
        n++;
      end else if (n > 0) begin
        chk("tx_periods", n, 48);
        if (tx_q.size() == 0)
          chk("unexpected_tx", cap, 48'h0);
        else begin
          want = tx_q.pop_front();
          chk("tx_frame", cap, want);
        end
        n = 0;
      end
    end
  end

  task automatic issue(input logic [5:0] idx, input logic [31:0] arg,
                       input logic [1:0] typ);
    int k;
    k = 0;
    @(negedge axi_clk);
    while (!cmd_ready && k < LIM) begin
      @(negedge axi_clk);
      k++;
    end
    if (k >= LIM) chk("issue_ready", cmd_ready, 1);
    cmd_index = idx;
    cmd_arg = arg;
    cmd_resp_type = typ;
    cmd_valid = 1'b1;
    @(posedge axi_clk);
    #1;
    accept_cyc = cyc;
    cmd_valid = 1'b0;
    cmd_index = 6'h3F;
    cmd_arg = $urandom;
    cmd_resp_type = ~typ;
  endtask

  task automatic wait_fall();
    logic p;
    p = sd_clk_out;
    for (int i = 0; i < 64; i++) begin
      @(posedge axi_clk);
      #1;
      if (p && !sd_clk_out) return;
      p = sd_clk_out;
    end
    chk("sd_clk_fall", sd_clk_out, 0);
  endtask

  task automatic reset_check();
    @(negedge axi_clk);
    axi_resetn = 1'b0;
    @(posedge axi_clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_sd_pins", {sd_clk_out, sd_cmd_out, sd_cmd_dir}, 3'b010);
    chk("rst_resp_fields", {resp_index, resp_status, resp_data}, 0);
    axi_resetn = 1'b1;
  endtask

  // Card model: answer dly sd clocks after the command ends.
  task automatic card(input logic [135:0] fr, input int nbits,
                      input int dly, input int abort_at);
    int k;
    k = 0;
    while (!sd_cmd_dir && k < LIM) begin
      @(posedge axi_clk);
      #1;
      k++;
    end
    while (sd_cmd_dir && k < LIM) begin
      @(posedge axi_clk);
      #1;
      k++;
    end
    if (k >= LIM) begin
      chk("card_wait_cmd", sd_cmd_dir, 0);
      return;
    end
    for (int i = 0; i < dly; i++) wait_fall();
    for (int j = 0; j < nbits; j++) begin
      if (j == abort_at) begin
        reset_check();
        sd_cmd_in = 1'b1;
        return;
      end
      sd_cmd_in = fr[nbits-1-j];
      wait_fall();
    end
    sd_cmd_in = 1'b1;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    @(negedge axi_clk);
    while (!(cmd_ready && !resp_valid) && k < LIM) begin
      @(negedge axi_clk);
      k++;
    end
    chk(nm, cmd_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    repeat (3) @(posedge axi_clk);
    #1;
    chk("init_cmd_ready", cmd_ready, 1);
    chk("init_pins", {sd_clk_out, sd_cmd_out, sd_cmd_dir}, 3'b010);
    chk("init_resp", {resp_valid, resp_index, resp_status, resp_data}, 0);
    axi_resetn = 1'b1;

    // CMD0, no response
    tx_q.push_back(48'h400000000095);
    push_resp(6'd0, 128'd0, 4'b0000);
    issue(6'd0, 32'd0, 2'd0);
    wait_idle("cmd0_idle");
    lat = valid_cyc - accept_cyc;
    chk("cmd0_latency_ok", (lat >= 440 && lat <= 464), 1);

    // CMD8, R7 good
    tx_q.push_back(48'h48000001AA87);
    push_resp(6'd8, 128'h1AA, 4'b0000);
    issue(6'd8, 32'h1AA, 2'd1);
    card({88'd0, 48'h08000001AA13}, 48, 5, -1);
    wait_idle("cmd8_idle");

    // CMD8, bit 20 flipped -> CRC error
    tx_q.push_back(48'h48000001AA87);
    push_resp(6'd8, 128'h0011AA, 4'b0010);
    issue(6'd8, 32'h1AA, 2'd1);
    card({88'd0, 48'h08000011AA13}, 48, 5, -1);
    wait_idle("cmd8_crc_idle");

    // CMD8, end bit 0
    tx_q.push_back(48'h48000001AA87);
    push_resp(6'd8, 128'h1AA, 4'b0100);
    issue(6'd8, 32'h1AA, 2'd1);
    card({88'd0, 48'h08000001AA12}, 48, 3, -1);
    wait_idle("cmd8_end_idle");

    // R3 style, CRC ignored
    tx_q.push_back(48'h48000001AA87);
    push_resp(6'd63, 128'h00FF8000, 4'b0000);
    issue(6'd8, 32'h1AA, 2'd2);
    card({88'd0, 48'h3F00FF8000FF}, 48, 2, -1);
    wait_idle("r3_idle");

    // CMD55, no card -> timeout
    tx_q.push_back(48'h770000000065);
    push_resp(6'd0, 128'd0, 4'b0001);
    issue(6'd55, 32'd0, 2'd1);
    wait_idle("timeout_idle");

    // CMD2, R2 long
    tx_q.push_back(48'h42000000004D);
    push_resp(6'd0, {16{8'hA5}}, 4'b0000);
    issue(6'd2, 32'd0, 2'd3);
    card({8'h3F, {16{8'hA5}}}, 136, 4, -1);
    wait_idle("r2_idle");

    // Reset during RX bit 20, then CMD0
    tx_q.push_back(48'h48000001AA87);
    issue(6'd8, 32'h1AA, 2'd1);
    card({88'd0, 48'h08000001AA13}, 48, 5, 20);
    tx_q.push_back(48'h400000000095);
    push_resp(6'd0, 128'd0, 4'b0000);
    issue(6'd0, 32'd0, 2'd0);
    wait_idle("post_rst_idle");

`ifdef SDIO_CMD_BUSY_EN
    // R1b with DAT0 held low -> busy timeout
    sd_dat0 = 1'b0;
    cmd_busy = 1'b1;
    tx_q.push_back(48'h48000001AA87);
    push_resp(6'd8, 128'h1AA, 4'b1000);
    issue(6'd8, 32'h1AA, 2'd1);
    cmd_busy = 1'b0;
    card({88'd0, 48'h08000001AA13}, 48, 5, -1);
    wait_idle("busy_idle");
    sd_dat0 = 1'b1;
`endif

    repeat (40) @(posedge axi_clk);
    chk("resp_queue_empty", exp_q.size(), 0);
    chk("tx_queue_empty", tx_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
